// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data Wishbone port arbiter: FSM states, the
// registered bus request and the fixed fetch byte select.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUS_IF = 2'd1,
        ARB_BUS_D  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        owner_e      owner;
    } mem_req_t;

    localparam logic [3:0] IF_SEL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core ports, the arbiter and the Wishbone fabric.
// Handshake: a port holds req with stable payload until gnt; each gnt yields exactly one rvalid pulse unless the fetch is flushed.
interface mem_port_arbiter_if;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_err_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    // Arbiter view.
    modport master (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    // Environment view: core ports plus the Wishbone slave.
    modport slave (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );

endinterface

// File: rtl/mem_port_arbiter_arb_watchdog.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last allowed
// cycle; with TIMEOUT_CYCLES=0 it never fires.
module arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = clk_i ^ rst_ni ^ clr_i ^ en_i;
        assign expired_o = 1'b0;
    end else begin : g_on
        localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

        logic [CW-1:0] cnt_q;

        // cnt_q is the number of bus cycles already spent, so the flag marks the TIMEOUT_CYCLES-th one.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i && (cnt_q != LAST)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign expired_o = en_i & (cnt_q == LAST);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one Wishbone-classic master between the fetch and load/store ports,
// one bus cycle per grant, response routed only to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY  = 1,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.master bus,
    output arb_state_e         state_o
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e    state_q;
    mem_req_t      req_q;
    logic [SW-1:0] streak_q;
    logic          last_d_q;
    logic          drop_q;
    logic          cyc_q;
    logic          if_rvalid_q, d_rvalid_q;
    logic          if_err_q, d_err_q;
    logic [31:0]   if_rdata_q, d_rdata_q;

    logic        idle, if_ok, d_wins_tie, pick_d, if_gnt, d_gnt;
    logic        wd_expired, slave_resp, bus_done, resp_err;
    logic [31:0] resp_dat;

    assign idle       = (state_q == ARB_IDLE);
    assign if_ok      = bus.if_req_i & ~bus.if_flush_i;
    assign d_wins_tie = (DATA_PRIORITY != 0) ? (streak_q < STREAK_MAX) : ~last_d_q;
    assign pick_d     = bus.d_req_i & (~if_ok | d_wins_tie);
    assign d_gnt      = idle & pick_d;
    assign if_gnt     = idle & if_ok & ~pick_d;

    // A watchdog expiry completes the cycle as an error with zero data.
    assign slave_resp = bus.wbm_ack_i | bus.wbm_err_i;
    assign bus_done   = ~idle & (slave_resp | wd_expired);
    assign resp_dat   = slave_resp ? bus.wbm_dat_i : 32'h0;
    assign resp_err   = bus.wbm_err_i | ~slave_resp;

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (if_gnt | d_gnt),
        .en_i      (~idle),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            req_q       <= '0;
            streak_q    <= '0;
            last_d_q    <= 1'b0;
            drop_q      <= 1'b0;
            cyc_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (d_gnt) begin
                        req_q    <= '{adr: bus.d_addr_i, dat: bus.d_wdata_i, sel: bus.d_be_i,
                                      we: bus.d_we_i, owner: OWNER_D};
                        state_q  <= ARB_BUS_D;
                        cyc_q    <= 1'b1;
                        last_d_q <= 1'b1;
                        if (bus.if_req_i && (streak_q < STREAK_MAX)) begin
                            streak_q <= streak_q + 1'b1;
                        end
                    end else if (if_gnt) begin
                        req_q    <= '{adr: bus.if_addr_i, dat: 32'h0, sel: IF_SEL,
                                      we: 1'b0, owner: OWNER_IF};
                        state_q  <= ARB_BUS_IF;
                        cyc_q    <= 1'b1;
                        last_d_q <= 1'b0;
                        streak_q <= '0;
                    end
                end
                ARB_BUS_IF, ARB_BUS_D: begin
                    if ((state_q == ARB_BUS_IF) && bus.if_flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (bus_done) begin
                        state_q <= ARB_IDLE;
                        cyc_q   <= 1'b0;
                        drop_q  <= 1'b0;
                        if (req_q.owner == OWNER_IF) begin
                            // A flush in the completing cycle still kills the response.
                            if_rvalid_q <= ~(drop_q | bus.if_flush_i);
                            if_rdata_q  <= resp_dat;
                            if_err_q    <= resp_err;
                        end else begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= resp_dat;
                            d_err_q    <= resp_err;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.d_gnt_o     = d_gnt;
    assign bus.if_rvalid_o = if_rvalid_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_err_o    = if_err_q;
    assign bus.d_rvalid_o  = d_rvalid_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.d_err_o     = d_err_q;

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = req_q.we;
    assign bus.wbm_sel_o = req_q.sel;
    assign bus.wbm_adr_o = req_q.adr;
    assign bus.wbm_dat_o = req_q.dat;

    assign state_o = state_q;

endmodule
